spike_shift_pipe: RTL and testbench
===================================

Name: spike_shift_pipe

Overview:
- Pipelined, multi-channel, bi-directional barrel shifter for thermometer/spike-encoded time vectors. Bit t of a channel word is a spike at time stamp t.
- Each of NUM_CH channels carries its own signed shift. Decoding is registered, followed by a logarithmic stage per shift bit.
- A valid/ready handshake with full backpressure lets it sit between spike-generation and temporal-compute blocks.
- Adds over the combinational shifter: pipelining, multiple channels, illegal-shift detection, and run-time wrap/saturate mode.

Parameters:
- LEN, 8, bits per channel (time stamps 0..LEN-1), >=2
- NUM_CH, 4, independent channels, >=1
- MAX_SHIFT_MAG, 2, max |shift|; legal shifts -MAX_SHIFT_MAG..+MAX_SHIFT_MAG; 1 <= MAX_SHIFT_MAG < LEN
- SHIFT_AS_ONE_HOT, 1, 1: shift field one-hot, SW = 2*MAX_SHIFT_MAG+1 bits; 0: binary, SW = $clog2(2*MAX_SHIFT_MAG+1) bits
- Derived: NSB = $clog2(MAX_SHIFT_MAG+1); latency L = NSB+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat
- in_data  in  NUM_CH*LEN  channel c at [c*LEN +: LEN]
- in_shift  in  NUM_CH*SW  channel c at [c*SW +: SW]
- in_wrap  in  1  1: circular shift modulo LEN; 0: shifted-out bits dropped, zero fill
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*LEN  shifted channels
- out_err  out  NUM_CH  per-channel illegal-shift flag for this beat

Behaviour:
- Shift value s:
  - One-hot mode: bit j of the field set means s = j - MAX_SHIFT_MAG. All-zero field means s = 0, not an error. More than one bit set means s = 0 and err = 1.
  - Binary mode: value v gives s = v - MAX_SHIFT_MAG. v > 2*MAX_SHIFT_MAG means s = 0 and err = 1.
- Shift semantics, positive s delays the spike: out[t] = in[t-s].
  - Wrap = 0: out[t] = 0 when t-s is outside 0..LEN-1.
  - Wrap = 1: the index is taken modulo LEN.
  - Negative s advances the spike symmetrically.
  - Multiple spikes (union) in a word are shifted together.
- Pipeline:
  - Stage 0 registers data, sign, magnitude (NSB bits), err and wrap for each channel.
  - Stage k (1..NSB) shifts by 2^(k-1) in the sign direction if magnitude bit k-1 is set.
  - The last stage drives the outputs. Sign, magnitude, wrap and err travel with the data.
- Handshake:
  - adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready.
  - A beat is accepted when in_valid && in_ready.
  - When adv = 0, every stage register, including the valid bits, holds.
  - Bubbles are not collapsed: a valid bit enters each stage every cycle adv = 1.
  - Latency is exactly L cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Outputs are registered except in_ready. out_data, out_err and the valid bits hold steady while out_valid && !out_ready.
- Reset (rst = 1 at a clk edge) behaviour:
  - All stage valid bits clear, out_valid = 0, out_data = 0, out_err = 0.
  - Beats in flight are discarded; mid-operation reset has the same effect.
  - in_ready = 1 in the first cycle after reset.
- Boundary cases:
  - s = ±MAX_SHIFT_MAG with wrap = 0 drops the edge bits.
  - An all-zero word stays all-zero.
  - An all-ones word shifted by +1 with wrap = 0 gives bit 0 = 0.
  - Simultaneous accept and output handoff in one cycle is legal.

Decomposition:
- Package spike_shift_pkg holds:
  - width functions: sw_f(MAX, ONE_HOT), nsb_f(MAX)
  - shift_decode function: returns sign, magnitude and err from a field plus the MAX and mode parameters
  - struct typedef for the per-channel stage payload (data, sign, mag, err, wrap)
- Sub-module spike_shift_stage(LEN, NUM_CH, STEP) implements one registered log stage for all channels, including the stall/hold logic.
- The top module instantiates it NSB times with STEP = 1, 2, 4, ...

Test Plan:
- LEN=8, MAX=2, one-hot; ch0 data=8'b0000_0010, shift=5'b01000 (s=+1), wrap=0 -> 3 cycles later out ch0=8'b0000_0100, err=0.
- Wrap: ch1 data=8'b1000_0001, s=+2, wrap=1 -> 8'b0000_0110. Same beat with wrap=0 -> 8'b0000_0100.
- Errors: ch2 one-hot field=5'b00011 -> data passes unshifted, out_err[2]=1. Binary mode, field=3'b111 -> unshifted, err=1. One-hot field all zero -> unshifted, err=0.
- Backpressure: stream 6 beats with out_ready low for cycles 4..7 -> no beat lost or duplicated, outputs stable while stalled, in-order delivery, in_ready low during the stall.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 next cycle, none of those beats ever appear; a new beat after reset emerges after exactly L cycles.
- Random sweep: all channels, all legal s, both wrap modes, random out_ready -> match the reference model out[t]=in[t-s].

Source files
------------

// File: rtl/spike_shift_pkg.sv
// Shared types, width helpers and shift-field decoder for the spike shifter.
package spike_shift_pkg;

  // Upper bounds for the per-channel payload fields. Each instance uses the
  // low LEN / NSB bits and keeps the remainder at zero. These bounds support
  // LEN up to 64, MAX_SHIFT_MAG up to 255 in binary mode, and a one-hot
  // shift field of at most 64 bits (MAX_SHIFT_MAG up to 31).
  localparam int PL_MAX_LEN = 64;
  localparam int PL_MAX_NSB = 8;
  localparam int PL_MAX_SW  = 64;

  // Per-channel payload carried down the pipeline.
  typedef struct packed {
    logic [PL_MAX_LEN-1:0] data;
    logic                  sign;   // 1: advance (negative shift)
    logic [PL_MAX_NSB-1:0] mag;    // |shift|
    logic                  err;    // illegal shift field seen
    logic                  wrap;   // circular shift
  } stage_pl_t;

  // Decoded shift field.
  typedef struct packed {
    logic                  sign;
    logic [PL_MAX_NSB-1:0] mag;
    logic                  err;
  } shift_dec_t;

  // Shift-field width for a given maximum magnitude and encoding.
  function automatic int sw_f(input int max_mag, input int one_hot);
    if (one_hot != 0) begin
      return 2 * max_mag + 1;
    end else begin
      return $clog2(2 * max_mag + 1);
    end
  endfunction

  // Number of magnitude bits, which is also the number of log stages.
  function automatic int nsb_f(input int max_mag);
    return $clog2(max_mag + 1);
  endfunction

  // Turn a (zero-extended) shift field into sign/magnitude/error.
  // Illegal fields decode to a zero shift with err set.
  function automatic shift_dec_t shift_decode(input logic [PL_MAX_SW-1:0] fld,
                                              input int max_mag,
                                              input int one_hot);
    shift_dec_t d;
    int         s;
    int         a;
    int         cnt;
    int         pos;
    logic [31:0] v;
    d   = '0;
    s   = 0;
    cnt = 0;
    pos = 0;
    v   = fld[31:0];
    if (one_hot != 0) begin
      for (int j = 0; j < PL_MAX_SW; j++) begin
        if ((j <= 2 * max_mag) && fld[j]) begin
          cnt = cnt + 1;
          pos = j;
        end else begin
          cnt = cnt;
        end
      end
      if (cnt == 1) begin
        s = pos - max_mag;
      end else if (cnt > 1) begin
        d.err = 1'b1;
      end else begin
        s = 0;  // empty one-hot field is a legal zero shift
      end
    end else begin
      if (v > 32'(2 * max_mag)) begin
        d.err = 1'b1;
      end else begin
        s = int'(v) - max_mag;
      end
    end
    a      = (s < 0) ? -s : s;
    d.sign = (s < 0);
    d.mag  = PL_MAX_NSB'(a);
    return d;
  endfunction

endpackage

// File: rtl/spike_shift_stage.sv
// One registered logarithmic shift stage for all channels. Shifts each
// channel by STEP in its sign direction when its magnitude bit for STEP is
// set, and holds everything while the pipeline is stalled.
module spike_shift_stage
  import spike_shift_pkg::*;
#(
  parameter int LEN    = 8,
  parameter int NUM_CH = 4,
  parameter int STEP   = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_adv,
  input  logic      i_valid,
  input  stage_pl_t i_pl [NUM_CH],
  output logic      o_valid,
  output stage_pl_t o_pl [NUM_CH]
);

  localparam int MAG_BIT = $clog2(STEP);

  stage_pl_t w_nxt [NUM_CH];
  stage_pl_t r_pl  [NUM_CH];
  logic      r_valid;

  // Shift a channel word by STEP: delay (toward higher time stamps) when
  // neg = 0, advance when neg = 1; circular when wrap is set.
  function automatic logic [LEN-1:0] step_shift(input logic [LEN-1:0] d,
                                                input logic neg,
                                                input logic wrap,
                                                input logic en);
    logic [LEN-1:0] r;
    if (!en) begin
      r = d;
    end else if (!neg) begin
      r = wrap ? ((d << STEP) | (d >> (LEN - STEP))) : (d << STEP);
    end else begin
      r = wrap ? ((d >> STEP) | (d << (LEN - STEP))) : (d >> STEP);
    end
    return r;
  endfunction

  // Next payload: data shifted by this stage, control fields passed along.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_nxt[c]                = i_pl[c];
      w_nxt[c].data           = '0;
      w_nxt[c].data[LEN-1:0]  = step_shift(i_pl[c].data[LEN-1:0], i_pl[c].sign,
                                           i_pl[c].wrap, i_pl[c].mag[MAG_BIT]);
    end
  end

  // Stage register: clears on reset, loads on advance, holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pl[c] <= '0;
      end
    end else if (i_adv) begin
      r_valid <= i_valid;
      for (int c = 0; c < NUM_CH; c++) begin
        r_pl[c] <= w_nxt[c];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pl    = r_pl;

endmodule

// File: rtl/spike_shift_pipe.sv
// Pipelined multi-channel bi-directional barrel shifter for spike-encoded
// time vectors. Stage 0 registers the decoded shift; NSB log stages follow.
module spike_shift_pipe
  import spike_shift_pkg::*;
#(
  parameter  int LEN              = 8,
  parameter  int NUM_CH           = 4,
  parameter  int MAX_SHIFT_MAG    = 2,
  parameter  int SHIFT_AS_ONE_HOT = 1,
  localparam int SW               = sw_f(MAX_SHIFT_MAG, SHIFT_AS_ONE_HOT),
  localparam int NSB              = nsb_f(MAX_SHIFT_MAG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_CH*LEN-1:0] in_data,
  input  logic [NUM_CH*SW-1:0]  in_shift,
  input  logic                  in_wrap,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_CH*LEN-1:0] out_data,
  output logic [NUM_CH-1:0]     out_err
);

  logic       w_adv;
  shift_dec_t w_dec    [NUM_CH];
  stage_pl_t  w_s0_nxt [NUM_CH];
  stage_pl_t  r_s0     [NUM_CH];
  logic       r_v0;
  stage_pl_t  w_pl     [NSB+1][NUM_CH];
  logic [NSB:0] w_v;

  // The whole pipeline moves together; a full output register that is not
  // being taken freezes every stage.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Decode each channel's shift field and build the stage-0 payload.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_dec[c]                  = shift_decode(PL_MAX_SW'(in_shift[c*SW +: SW]),
                                               MAX_SHIFT_MAG, SHIFT_AS_ONE_HOT);
      w_s0_nxt[c]               = '0;
      w_s0_nxt[c].data[LEN-1:0] = in_data[c*LEN +: LEN];
      w_s0_nxt[c].sign          = w_dec[c].sign;
      w_s0_nxt[c].mag           = w_dec[c].mag;
      w_s0_nxt[c].err           = w_dec[c].err;
      w_s0_nxt[c].wrap          = in_wrap;
    end
  end

  // Stage 0 register: captures the accepted beat (or a bubble) on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_s0[c] <= '0;
      end
    end else if (w_adv) begin
      r_v0 <= in_valid;
      for (int c = 0; c < NUM_CH; c++) begin
        r_s0[c] <= w_s0_nxt[c];
      end
    end
  end

  assign w_pl[0] = r_s0;
  assign w_v[0]  = r_v0;

  // Log stages: stage k shifts by 2^(k-1).
  for (genvar k = 1; k <= NSB; k++) begin : g_stage
    spike_shift_stage #(
      .LEN    (LEN),
      .NUM_CH (NUM_CH),
      .STEP   (1 << (k - 1))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_adv),
      .i_valid (w_v[k-1]),
      .i_pl    (w_pl[k-1]),
      .o_valid (w_v[k]),
      .o_pl    (w_pl[k])
    );
  end

  assign out_valid = w_v[NSB];

  // Unpack the last stage register onto the output buses.
  always_comb begin
    out_data = '0;
    out_err  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_data[c*LEN +: LEN] = w_pl[NSB][c].data[LEN-1:0];
      out_err[c]             = w_pl[NSB][c].err;
    end
  end

endmodule

// File: tb/tb_spike_shift_pipe.sv
// Directed + scoreboarded bench for spike_shift_pipe (LEN=8, NUM_CH=4, MAX=2).
module tb_spike_shift_pipe;

  localparam int L = 3;  // NSB + 1 for MAX_SHIFT_MAG = 2

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_wrap;
  logic [31:0] in_data;
  logic [19:0] in_shift;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_err;

  logic        b_in_valid, b_in_ready, b_in_wrap;
  logic [31:0] b_in_data;
  logic [11:0] b_in_shift;
  logic        b_out_valid, b_out_ready;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [19:0] f;
    logic        w;
    logic [31:0] ed;
    logic [3:0]  ee;
  } vec_t;

  vec_t vecs [7];

  spike_shift_pipe #(.LEN(8), .NUM_CH(4), .MAX_SHIFT_MAG(2), .SHIFT_AS_ONE_HOT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_wrap(in_wrap),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  spike_shift_pipe #(.LEN(8), .NUM_CH(4), .MAX_SHIFT_MAG(2), .SHIFT_AS_ONE_HOT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_shift(b_in_shift), .in_wrap(b_in_wrap),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out[t] = in[t-s], modulo LEN when wrapping, zero outside otherwise.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic w);
    logic [7:0] r;
    int src;
    r = 8'h00;
    for (int t = 0; t < 8; t++) begin
      src = t - s;
      if (w) src = (src + 8) % 8;
      if (src >= 0 && src < 8) r[t] = d[src];
    end
    return r;
  endfunction

  task automatic make_beat(output logic [31:0] d, output logic [19:0] f, output logic w,
                           output logic [31:0] ed, output logic [3:0] ee);
    logic [7:0] dc;
    logic [4:0] fc;
    int r;
    d = '0; f = '0; ed = '0; ee = '0;
    w = 1'($urandom_range(0, 1));
    for (int c = 0; c < 4; c++) begin
      dc = 8'($urandom);
      r  = int'($urandom_range(0, 5));
      if (r < 5) begin
        fc = 5'(1 << r);
        ed[c*8 +: 8] = ref_shift(dc, r - 2, w);
      end else begin
        fc = 5'b10100;
        ed[c*8 +: 8] = dc;
        ee[c] = 1'b1;
      end
      d[c*8 +: 8] = dc;
      f[c*5 +: 5] = fc;
    end
  endtask

  task automatic run_vec(input int idx);
    int n;
    @(negedge clk);
    chk("vec_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = vecs[idx].d; in_shift = vecs[idx].f; in_wrap = vecs[idx].w;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), n, L);
    chk($sformatf("vec%0d_data", idx), out_data, vecs[idx].ed);
    chk($sformatf("vec%0d_err", idx), out_err, vecs[idx].ee);
  endtask

  // mode 0: out_ready low in cycles 4..7; mode 1: random out_ready.
  task automatic stream(input int nbeats, input int mode);
    logic [31:0] qd[$];
    logic [3:0]  qe[$];
    logic [31:0] d, ed, hold_d, exp_d;
    logic [3:0]  ee, hold_e, exp_e;
    logic [19:0] f;
    logic        w, stall_prev;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; hold_d = '0; hold_e = '0;
    make_beat(d, f, w, ed, ee);
    while (got < nbeats && cyc < 600) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("stall_valid_hold", out_valid, 1'b1);
        chk("stall_data_hold", out_data, hold_d);
        chk("stall_err_hold", out_err, hold_e);
      end
      if (mode == 0) out_ready = (cyc >= 4 && cyc <= 7) ? 1'b0 : 1'b1;
      else           out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < nbeats);
      in_data = d; in_shift = f; in_wrap = w;
      #1;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (qd.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          exp_d = qd.pop_front();
          exp_e = qe.pop_front();
          chk("stream_data", out_data, exp_d);
          chk("stream_err", out_err, exp_e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        qd.push_back(ed);
        qe.push_back(ee);
        sent++;
        make_beat(d, f, w, ed, ee);
      end
      stall_prev = out_valid && !out_ready;
      hold_d = out_data;
      hold_e = out_err;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, nbeats);
    chk("stream_leftover", qd.size(), 0);
  endtask

  initial begin
    int n, seen;
    //            data          {ch3,ch2,ch1,ch0} fields                     wrap  expected data  err
    vecs[0] = '{32'hC35A8102, {5'b00000, 5'b00011, 5'b10000, 5'b01000}, 1'b1, 32'hC35A0604, 4'b0100};
    vecs[1] = '{32'hC35A8102, {5'b00000, 5'b00011, 5'b10000, 5'b01000}, 1'b0, 32'hC35A0404, 4'b0100};
    vecs[2] = '{32'h8100FFFF, {5'b00001, 5'b10000, 5'b00010, 5'b01000}, 1'b0, 32'h20007FFE, 4'b0000};
    vecs[3] = '{32'h81C001FF, {5'b00001, 5'b10000, 5'b00010, 5'b01000}, 1'b1, 32'h600380FF, 4'b0000};
    vecs[4] = '{32'h12345678, {5'b00100, 5'b00100, 5'b00100, 5'b00100}, 1'b0, 32'h12345678, 4'b0000};
    vecs[5] = '{32'hA53C0FF0, {5'b01100, 5'b00100, 5'b10001, 5'b11111}, 1'b0, 32'hA53C0FF0, 4'b1011};
    vecs[6] = '{32'h4080C003, {5'b01000, 5'b00010, 5'b10000, 5'b00001}, 1'b0, 32'h80400000, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_wrap = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_shift = '0; b_in_wrap = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", out_err, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Binary-encoded shift field instance.
    @(negedge clk);
    chk("bin_in_ready", b_in_ready, 1'b1);
    b_in_valid = 1'b1; b_in_data = 32'hC35A8102; b_in_wrap = 1'b0;
    b_in_shift = {3'b101, 3'b111, 3'b000, 3'b011};
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bin_latency", n, L);
    chk("bin_data", b_out_data, 32'hC35A2004);
    chk("bin_err", b_out_err, 4'b1100);

    // Backpressure stream, then random sweep.
    stream(6, 0);
    stream(60, 1);

    // Reset with three beats in flight: none may be delivered afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_shift = {4{5'b00100}}; in_wrap = 1'b0; in_data = 32'h11111111;
    @(negedge clk);
    in_data = 32'h22222222;
    @(negedge clk);
    in_data = 32'h33333333;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_ghost", seen, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
